// File: rtl/osmlgd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : osmlgd_pkg
// Description : Shared types and helpers for the iterative OSMLG decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package osmlgd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FLIP  = 2'd2
    } state_t;

    // Widest mask the popcount helper accepts; callers zero-extend.
    localparam int c_popcnt_w = 1024;

    function automatic int vote_width(input int m);
        return $clog2(m + 1);
    endfunction

    function automatic int iter_width(input int max_iter);
        return $clog2(max_iter + 1);
    endfunction

    function automatic int flip_cnt_width(input int n, input int max_iter);
        return $clog2(n * max_iter + 1);
    endfunction

    function automatic int unsigned popcount(input logic [c_popcnt_w-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < c_popcnt_w; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/osmlgd_vote_acc.sv
`default_nettype none
// ============================================================================
// Module      : osmlgd_vote_acc
// Description : N-lane saturating failed-check vote counters with threshold.
// Revision    : 1.0 - initial release
// ============================================================================
module osmlgd_vote_acc
    import osmlgd_pkg::*;
#(
    parameter int N   = 256,
    parameter int VW  = 8,
    parameter int THR = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc_en,
    input  logic [N-1:0] inc_mask,
    output logic [N-1:0] flip_mask
);

    localparam logic [VW-1:0] c_vmax = '1;

    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [VW-1:0] r_vote;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_vote <= '0;
            end else if (clr) begin
                r_vote <= '0;
            end else if (inc_en && inc_mask[j] && (r_vote != c_vmax)) begin
                r_vote <= r_vote + VW'(1);
            end
        end

        assign flip_mask[j] = (32'(r_vote) >= THR);
    end

endmodule
`default_nettype wire

// File: rtl/osmlgd_iter_dec.sv
`default_nettype none
// ============================================================================
// Module      : osmlgd_iter_dec
// Description : Iterative bit-flipping OSMLG LDPC decoder, one H row per cycle.
//               Optional flip_cnt output enabled by macro OSMLGD_FLIPCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module osmlgd_iter_dec
    import osmlgd_pkg::*;
#(
    parameter int N        = 256,
    parameter int M        = 128,
    parameter int MAX_ITER = 4,
    parameter int THR      = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              work,
    input  logic [N-1:0]                      tx,
    input  logic                              h_we,
    input  logic [$clog2(M)-1:0]              h_addr,
    input  logic [N-1:0]                      h_row,
    output logic                              free,
    output logic [N-1:0]                      deout,
    output logic                              valid,
    output logic                              success,
    output logic [iter_width(MAX_ITER)-1:0]   iter_used
`ifdef OSMLGD_FLIPCNT_EN
    ,
    output logic [flip_cnt_width(N, MAX_ITER)-1:0] flip_cnt
`endif
);

    localparam int c_vw = vote_width(M);
    localparam int c_iw = iter_width(MAX_ITER);
    localparam int c_aw = $clog2(M);

    // H is a plain register file and is deliberately left out of reset.
    logic [N-1:0]      r_harray [M];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N-1:0]      r_cw;
    logic [c_aw-1:0]   r_row;
    logic [c_iw-1:0]   r_iter;
    logic              r_syn_any;
    logic              r_free;
    logic              r_valid;
    logic              r_success;
    logic [N-1:0]      r_deout;
    logic [c_iw-1:0]   r_iter_used;

    logic [N-1:0]      w_hrow;
    logic [N-1:0]      w_flip_mask;
    logic              w_parity;
    logic              w_last_row;
    logic              w_any_flip;
    logic              w_addr_ok;
    logic              w_accept;
    logic              w_h_wr;
    logic              w_inc_en;
    logic              w_done_ok;
    logic              w_done_fail;
    logic              w_do_flip;
    logic              w_exit;
    logic              w_clr;

    assign w_hrow     = r_harray[r_row];
    assign w_parity   = ^(w_hrow & r_cw);
    assign w_last_row = (32'(r_row) == (M - 1));
    assign w_any_flip = |w_flip_mask;
    assign w_addr_ok  = (32'(h_addr) < M);
    assign w_exit     = w_done_ok | w_done_fail;
    assign w_clr      = w_accept | w_do_flip;

    osmlgd_vote_acc #(
        .N   (N),
        .VW  (c_vw),
        .THR (THR)
    ) u_vote_acc (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_clr),
        .inc_en    (w_inc_en),
        .inc_mask  (w_hrow),
        .flip_mask (w_flip_mask)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (work) w_state_nxt = CHECK;
            CHECK:   if (w_last_row) w_state_nxt = FLIP;
            FLIP:    w_state_nxt = w_do_flip ? CHECK : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_accept    = 1'b0;
        w_h_wr      = 1'b0;
        w_inc_en    = 1'b0;
        w_done_ok   = 1'b0;
        w_done_fail = 1'b0;
        w_do_flip   = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = work;
                w_h_wr   = h_we && w_addr_ok;
            end
            CHECK: w_inc_en = w_parity;
            FLIP: begin
                if (!r_syn_any) begin
                    w_done_ok = 1'b1;
                end else if ((r_iter == c_iw'(MAX_ITER)) || !w_any_flip) begin
                    w_done_fail = 1'b1;
                end else begin
                    w_do_flip = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_h_wr) begin
            r_harray[h_addr] <= h_row;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cw        <= '0;
            r_row       <= '0;
            r_iter      <= '0;
            r_syn_any   <= 1'b0;
            r_free      <= 1'b1;
            r_valid     <= 1'b0;
            r_success   <= 1'b0;
            r_deout     <= '0;
            r_iter_used <= '0;
        end else begin
            r_valid <= w_exit;
            if (w_accept) begin
                r_cw      <= tx;
                r_row     <= '0;
                r_iter    <= '0;
                r_syn_any <= 1'b0;
                r_free    <= 1'b0;
            end
            if (r_state == CHECK) begin
                if (w_parity) begin
                    r_syn_any <= 1'b1;
                end
                r_row <= w_last_row ? '0 : r_row + c_aw'(1);
            end
            if (w_do_flip) begin
                r_cw      <= r_cw ^ w_flip_mask;
                r_iter    <= r_iter + c_iw'(1);
                r_syn_any <= 1'b0;
                r_row     <= '0;
            end
            if (w_exit) begin
                r_deout     <= r_cw;
                r_success   <= w_done_ok;
                r_iter_used <= r_iter;
                r_free      <= 1'b1;
            end
        end
    end

    assign free      = r_free;
    assign deout     = r_deout;
    assign valid     = r_valid;
    assign success   = r_success;
    assign iter_used = r_iter_used;

`ifdef OSMLGD_FLIPCNT_EN
    localparam int c_fw = flip_cnt_width(N, MAX_ITER);

    logic [c_fw-1:0]       r_flip_acc;
    logic [c_fw-1:0]       r_flip_cnt;
    logic [c_popcnt_w-1:0] w_mask_ext;

    assign w_mask_ext = c_popcnt_w'(w_flip_mask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flip_acc <= '0;
            r_flip_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_flip_acc <= '0;
            end else if (w_do_flip) begin
                r_flip_acc <= r_flip_acc + c_fw'(popcount(w_mask_ext));
            end
            if (w_exit) begin
                r_flip_cnt <= r_flip_acc;
            end
        end
    end

    assign flip_cnt = r_flip_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_osmlgd_iter_dec.sv
`default_nettype none
// ============================================================================
// Module      : tb_osmlgd_iter_dec
// Description : Self-checking bench for osmlgd_iter_dec on the (15,7) EG code.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osmlgd_iter_dec;

    localparam int N        = 15;
    localparam int M        = 15;
    localparam int MAX_ITER = 2;
    localparam int THR      = 3;
    localparam int IW       = $clog2(MAX_ITER + 1);
    localparam int FW       = $clog2(N * MAX_ITER + 1);
    localparam int BUDGET   = 200;

    logic                 clk;
    logic                 rst;
    logic                 work;
    logic [N-1:0]         tx;
    logic                 h_we;
    logic [$clog2(M)-1:0] h_addr;
    logic [N-1:0]         h_row;
    logic                 free;
    logic [N-1:0]         deout;
    logic                 valid;
    logic                 success;
    logic [IW-1:0]        iter_used;
`ifdef OSMLGD_FLIPCNT_EN
    logic [FW-1:0]        flip_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] hmod [M];
    logic [N-1:0] cws [$];

    osmlgd_iter_dec #(
        .N        (N),
        .M        (M),
        .MAX_ITER (MAX_ITER),
        .THR      (THR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .work      (work),
        .tx        (tx),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_row     (h_row),
        .free      (free),
        .deout     (deout),
        .valid     (valid),
        .success   (success),
        .iter_used (iter_used)
`ifdef OSMLGD_FLIPCNT_EN
        ,
        .flip_cnt  (flip_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Whole-pass reference: full syndrome, vote tally, threshold flip.
    function automatic void ref_decode(input logic [N-1:0] w, output logic [N-1:0] d,
                                       output logic s, output int it, output int fc,
                                       output int lat);
        logic [N-1:0] cw;
        logic [N-1:0] mask;
        int           votes [N];
        bit           any_fail;
        bit           done;
        cw = w; it = 0; fc = 0; s = 1'b0; done = 0;
        while (!done) begin
            any_fail = 0;
            for (int j = 0; j < N; j++) votes[j] = 0;
            for (int r = 0; r < M; r++) begin
                if (^(hmod[r] & cw)) begin
                    any_fail = 1;
                    for (int j = 0; j < N; j++) if (hmod[r][j]) votes[j]++;
                end
            end
            mask = '0;
            for (int j = 0; j < N; j++) if (votes[j] >= THR) mask[j] = 1'b1;
            if (!any_fail) begin
                s = 1'b1; done = 1;
            end else if (it == MAX_ITER || mask == '0) begin
                done = 1;
            end else begin
                cw = cw ^ mask; fc += $countones(mask); it++;
            end
        end
        d = cw;
        lat = (it + 1) * (M + 1);
    endfunction

    task automatic build_dsc();
        int pts [4] = '{0, 1, 3, 7};
        for (int r = 0; r < M; r++) begin
            hmod[r] = '0;
            for (int p = 0; p < 4; p++) hmod[r][(pts[p] + r) % N] = 1'b1;
        end
        cws.delete();
        for (int v = 0; v < (1 << N); v++) begin
            logic [N-1:0] w;
            bit ok;
            w = N'(v); ok = 1;
            for (int r = 0; r < M; r++) if (^(hmod[r] & w)) ok = 0;
            if (ok) cws.push_back(w);
        end
    endtask

    task automatic load_h();
        for (int r = 0; r < M; r++) begin
            @(negedge clk);
            h_we = 1'b1; h_addr = ($clog2(M))'(r); h_row = hmod[r];
        end
        @(negedge clk);
        h_we = 1'b0;
    endtask

    task automatic start_work(input logic [N-1:0] w);
        @(negedge clk);
        tx = w; work = 1'b1;
        @(posedge clk); #1;
        work = 1'b0;
    endtask

    task automatic wait_valid(input int lat0, output int lat, output bit tmo);
        lat = lat0; tmo = 1;
        while (lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
            if (valid) begin
                tmo = 0;
                break;
            end
        end
    endtask

    function automatic logic [N-1:0] pick_cw();
        return cws[1 + $urandom_range(cws.size() - 2)];
    endfunction

    task automatic test_reset();
        bit seen;
        rst = 1'b0; work = 1'b0; h_we = 1'b0; tx = '0; h_addr = '0; h_row = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (free !== 1'b1) begin n_fail++; $display("FAIL rst_free got=%b exp=1", free); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", valid); end
        n_checks++; if (deout !== '0) begin n_fail++; $display("FAIL rst_deout got=%h exp=0", deout); end
        n_checks++; if (success !== 1'b0) begin n_fail++; $display("FAIL rst_success got=%b exp=0", success); end
        n_checks++; if (iter_used !== '0) begin n_fail++; $display("FAIL rst_iter got=%0d exp=0", iter_used); end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (valid || !free) seen = 1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL rst_idle got=activity exp=idle"); end
    endtask

    task automatic test_single_error();
        logic [N-1:0] cw;
        int lat;
        bit tmo;
        cw = pick_cw();
        start_work(cw ^ (N'(1) << 5));
        wait_valid(0, lat, tmo);
        n_checks++; if (tmo || lat != 2 * (M + 1)) begin n_fail++; $display("FAIL se_latency got=%0d exp=%0d", lat, 2 * (M + 1)); end
        n_checks++; if (deout !== cw) begin n_fail++; $display("FAIL se_deout got=%h exp=%h", deout, cw); end
        n_checks++; if (success !== 1'b1) begin n_fail++; $display("FAIL se_success got=%b exp=1", success); end
        n_checks++; if (iter_used !== IW'(1)) begin n_fail++; $display("FAIL se_iter got=%0d exp=1", iter_used); end
`ifdef OSMLGD_FLIPCNT_EN
        n_checks++; if (flip_cnt !== FW'(1)) begin n_fail++; $display("FAIL se_flipcnt got=%0d exp=1", flip_cnt); end
`endif
        @(posedge clk); #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL se_pulse got=%b exp=0", valid); end
        n_checks++; if (deout !== cw || free !== 1'b1) begin n_fail++; $display("FAIL se_hold got=%h/%b exp=%h/1", deout, free, cw); end
    endtask

    task automatic test_decodes(input int count, input bit any_word);
        logic [N-1:0] cw, w, d_exp;
        logic         s_exp;
        int           it_exp, fc_exp, lat_exp, lat, a, b;
        bit           tmo;
        for (int k = 0; k < count; k++) begin
            cw = any_word ? N'($urandom()) : pick_cw();
            case (k % 4)
                0: w = cw;
                1: w = cw ^ (N'(1) << $urandom_range(N - 1));
                2: begin
                    a = $urandom_range(N - 1);
                    b = (a + 1 + $urandom_range(N - 2)) % N;
                    w = cw ^ (N'(1) << a) ^ (N'(1) << b);
                end
                default: begin
                    w = cw;
                    while ($countones(w ^ cw) < 5) w[$urandom_range(N - 1)] = ~cw[0] ^ cw[0] ^ ~w[0] ^ w[0] ^ 1'b1 ^ w[0] ^ w[0];
                end
            endcase
            ref_decode(w, d_exp, s_exp, it_exp, fc_exp, lat_exp);
            start_work(w);
            wait_valid(0, lat, tmo);
            n_checks++; if (tmo || lat != lat_exp) begin n_fail++; $display("FAIL dec_latency k=%0d got=%0d exp=%0d", k, lat, lat_exp); end
            n_checks++; if (deout !== d_exp) begin n_fail++; $display("FAIL dec_deout k=%0d got=%h exp=%h", k, deout, d_exp); end
            n_checks++; if (success !== s_exp) begin n_fail++; $display("FAIL dec_success k=%0d got=%b exp=%b", k, success, s_exp); end
            n_checks++; if (iter_used !== IW'(it_exp)) begin n_fail++; $display("FAIL dec_iter k=%0d got=%0d exp=%0d", k, iter_used, it_exp); end
`ifdef OSMLGD_FLIPCNT_EN
            n_checks++; if (flip_cnt !== FW'(fc_exp)) begin n_fail++; $display("FAIL dec_flipcnt k=%0d got=%0d exp=%0d", k, flip_cnt, fc_exp); end
`endif
            if (!any_word && (k % 4) != 3) begin
                n_checks++; if (deout !== cw || success !== 1'b1) begin n_fail++; $display("FAIL dec_correct k=%0d got=%h/%b exp=%h/1", k, deout, success, cw); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] w1, w2, d_exp;
        logic         s_exp;
        int           it_exp, fc_exp, lat_exp, lat;
        bit           tmo;
        w1 = pick_cw() ^ (N'(1) << $urandom_range(N - 1));
        w2 = pick_cw() ^ (N'(1) << $urandom_range(N - 1));
        start_work(w1);
        wait_valid(0, lat, tmo);
        tx = w2; work = 1'b1;
        @(posedge clk); #1;
        work = 1'b0;
        n_checks++; if (free !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got=free%b exp=free0", free); end
        ref_decode(w2, d_exp, s_exp, it_exp, fc_exp, lat_exp);
        wait_valid(0, lat, tmo);
        n_checks++; if (tmo || lat != lat_exp) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, lat_exp); end
        n_checks++; if (deout !== d_exp || success !== s_exp) begin n_fail++; $display("FAIL b2b_result got=%h/%b exp=%h/%b", deout, success, d_exp, s_exp); end
    endtask

    task automatic test_work_ignored();
        logic [N-1:0] w1, d_exp;
        logic         s_exp;
        int           it_exp, fc_exp, lat_exp, lat;
        bit           tmo;
        w1 = pick_cw() ^ (N'(1) << $urandom_range(N - 1));
        ref_decode(w1, d_exp, s_exp, it_exp, fc_exp, lat_exp);
        start_work(w1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        tx = ~w1; work = 1'b1;
        @(posedge clk); #1;
        work = 1'b0;
        wait_valid(5, lat, tmo);
        n_checks++; if (tmo || lat != lat_exp) begin n_fail++; $display("FAIL wig_latency got=%0d exp=%0d", lat, lat_exp); end
        n_checks++; if (deout !== d_exp || iter_used !== IW'(it_exp)) begin n_fail++; $display("FAIL wig_result got=%h/%0d exp=%h/%0d", deout, iter_used, d_exp, it_exp); end
        repeat (2 * (M + 1)) begin
            @(posedge clk); #1;
            if (valid) tmo = 1;
        end
        n_checks++; if (tmo) begin n_fail++; $display("FAIL wig_queued got=extra_valid exp=none"); end
    endtask

    task automatic test_hwe_locked();
        logic [N-1:0] cw;
        int           lat;
        bit           tmo;
        cw = '0;
        foreach (cws[i]) if (cws[i][0]) cw = cws[i];
        start_work(pick_cw() ^ N'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        h_we = 1'b1; h_addr = '0; h_row = N'(1);
        @(negedge clk);
        h_we = 1'b0;
        wait_valid(3, lat, tmo);
        start_work(cw);
        wait_valid(0, lat, tmo);
        n_checks++; if (tmo || lat != M + 1) begin n_fail++; $display("FAIL hwe_latency got=%0d exp=%0d", lat, M + 1); end
        n_checks++; if (success !== 1'b1 || deout !== cw) begin n_fail++; $display("FAIL hwe_locked got=%b/%h exp=1/%h", success, deout, cw); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] w;
        int           lat;
        bit           tmo;
        w = pick_cw();
        start_work(w ^ (N'(1) << 3));
        repeat (9) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        n_checks++; if (free !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ctl got=%b/%b exp=1/0", free, valid); end
        n_checks++; if (deout !== '0 || success !== 1'b0 || iter_used !== '0) begin n_fail++; $display("FAIL rmid_out got=%h/%b/%0d exp=0/0/0", deout, success, iter_used); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tmo = 0;
        repeat (3 * (M + 1)) begin
            @(posedge clk); #1;
            if (valid) tmo = 1;
        end
        n_checks++; if (tmo) begin n_fail++; $display("FAIL rmid_novalid got=valid exp=none"); end
        start_work(w ^ (N'(1) << 9));
        wait_valid(0, lat, tmo);
        n_checks++; if (tmo || lat != 2 * (M + 1) || deout !== w || success !== 1'b1) begin n_fail++; $display("FAIL rmid_next got=%0d/%h/%b exp=%0d/%h/1", lat, deout, success, 2 * (M + 1), w); end
    endtask

    task automatic test_random_h();
        for (int r = 0; r < M; r++) hmod[r] = N'($urandom()) & N'($urandom());
        load_h();
        test_decodes(16, 1'b1);
    endtask

    initial begin
        clk = 1'b0;
        test_reset();
        build_dsc();
        load_h();
        test_single_error();
        test_decodes(24, 1'b0);
        test_back_to_back();
        test_work_ignored();
        test_hwe_locked();
        test_reset_mid();
        test_random_h();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
